// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, response codes and the byte-lane decode used by
// the memory responder and its storage array.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

    // Little-endian lane mask; callers only pass sizes already checked as legal.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] mask;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << addr;
            HSIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
            default:    mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word-addressed storage with per-byte write enables and asynchronous read.
// Each byte lane is its own array so lane writes never share a driver.
module ahb_mem_array
    import ahb_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane [DEPTH];

            always_ff @(posedge clk) begin
                if (i_we && i_be[gi]) begin
                    r_lane[i_waddr] <= i_wdata[gi*8 +: 8];
                end
            end

            assign o_rdata[gi*8 +: 8] = r_lane[i_raddr];
        end
    endgenerate

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder: fixed wait states, byte/half/word access into a
// word array, and a two-cycle ERROR response for illegal transfers.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int          MEM_DEPTH   = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hrst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic [1:0]  hresp
);

    localparam int          AW           = $clog2(MEM_DEPTH);
    localparam logic [32:0] WINDOW_BYTES = 33'(4 * MEM_DEPTH);
    localparam logic [2:0]  WS_LOAD      = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    slave_state_e  r_state;
    logic          r_hreadyout;
    logic [1:0]    r_hresp;
    logic [2:0]    r_wait_cnt;
    logic          r_write;
    logic [2:0]    r_size;
    logic [1:0]    r_byte_off;
    logic [AW-1:0] r_word_idx;

    logic [32:0]   w_offset;
    logic          w_in_window;
    logic          w_size_ok;
    logic          w_aligned;
    logic          w_legal;
    logic          w_trans_valid;
    logic          w_accept;
    logic          w_we;
    logic [3:0]    w_be;
    logic [31:0]   w_rdata;
    logic          w_unused_ok;

    // 33-bit subtraction: an address below the base wraps to a huge offset.
    assign w_offset      = {1'b0, haddr} - {1'b0, ADDR_BASE};
    assign w_in_window   = (w_offset < WINDOW_BYTES);
    assign w_size_ok     = (hsize <= HSIZE_WORD);
    assign w_legal       = w_in_window && w_size_ok && w_aligned;
    assign w_trans_valid = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

    always_comb begin
        w_aligned = 1'b1;
        case (hsize)
            HSIZE_HALF: w_aligned = ~haddr[0];
            HSIZE_WORD: w_aligned = (haddr[1:0] == 2'b00);
            default:    w_aligned = 1'b1;
        endcase
    end

    // Address phases are only sampled in states that drive hreadyout high.
    assign w_accept = hsel && hready && w_trans_valid && r_hreadyout;

    always_ff @(posedge hclk) begin
        if (hrst) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_wait_cnt  <= 3'd0;
            r_write     <= 1'b0;
            r_size      <= 3'd0;
            r_byte_off  <= 2'd0;
            r_word_idx  <= '0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_wait_cnt == 3'd0) begin
                        r_state     <= ST_DATA;
                        r_hreadyout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    if (w_accept) begin
                        r_write    <= hwrite;
                        r_size     <= hsize;
                        r_byte_off <= haddr[1:0];
                        r_word_idx <= w_offset[AW+1:2];
                        if (w_legal) begin
                            r_hresp <= HRESP_OKAY;
                            if (WAIT_STATES > 0) begin
                                r_state     <= ST_WAIT;
                                r_wait_cnt  <= WS_LOAD;
                                r_hreadyout <= 1'b0;
                            end else begin
                                r_state     <= ST_DATA;
                                r_hreadyout <= 1'b1;
                            end
                        end else begin
                            r_state     <= ST_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= HRESP_ERROR;
                        end
                    end else begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Write lands on the edge closing DATA; reset on that edge abandons it.
    assign w_we = (r_state == ST_DATA) && r_write && !hrst;
    assign w_be = byte_en(r_size, r_byte_off);

    ahb_mem_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (hclk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_waddr (r_word_idx),
        .i_wdata (hwdata),
        .i_raddr (r_word_idx),
        .o_rdata (w_rdata)
    );

    assign hrdata    = (r_state == ST_DATA && !r_write) ? w_rdata : 32'h0;
    assign hreadyout = r_hreadyout;
    assign hresp     = r_hresp;

    assign w_unused_ok = ^{hburst, hprot, w_offset};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench: one instance with one wait state, one with zero wait states.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    logic        hclk;
    logic        hrst;
    logic        hsel0, hsel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready_en;
    logic        hready0, hready1;
    logic [31:0] hrdata0, hrdata1;
    logic        hreadyout0, hreadyout1;
    logic [1:0]  hresp0, hresp1;

    int n_cmp = 0;
    int n_err = 0;

    assign hready1 = hreadyout1 & hready_en;
    assign hready0 = hreadyout0;

    ahb_slave_mem #(.MEM_DEPTH(1024), .ADDR_BASE(32'h0), .WAIT_STATES(1)) u_dut1 (
        .hclk(hclk), .hrst(hrst), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata), .hready(hready1), .hrdata(hrdata1),
        .hreadyout(hreadyout1), .hresp(hresp1)
    );

    ahb_slave_mem #(.MEM_DEPTH(1024), .ADDR_BASE(32'h0), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hrst(hrst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata), .hready(hready0), .hrdata(hrdata0),
        .hreadyout(hreadyout0), .hresp(hresp0)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_bus();
        hsel0  = 1'b0;
        hsel1  = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    // Full transfer on the one-wait-state instance; captures both response cycles.
    task automatic xfer1(input logic [31:0] a, input logic w, input logic [2:0] s,
                         input logic [31:0] d, output logic [2:0] c1,
                         output logic [2:0] c2, output logic [31:0] rd);
        hsel1  = 1'b1;
        haddr  = a;
        htrans = HTRANS_NONSEQ;
        hwrite = w;
        hsize  = s;
        hwdata = 32'h0;
        step();
        c1 = {hreadyout1, hresp1};
        idle_bus();
        hwdata = d;
        step();
        c2 = {hreadyout1, hresp1};
        rd = hrdata1;
        step();
        $display("xfer %s addr=%08h size=%0d wdata=%08h rdata=%08h resp=%b/%b",
                 w ? "WR" : "RD", a, s, d, rd, c1, c2);
    endtask

    task automatic test_reset();
        idle_bus();
        haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0; hwdata = 32'h0;
        hburst = 3'd0; hprot = 4'd0; hready_en = 1'b1;
        hrst = 1'b1;
        step();
        step();
        n_cmp++; if ({hreadyout1, hresp1} !== 3'b100) begin n_err++; $display("FAIL reset_ws1_ready_resp: got %b want 100", {hreadyout1, hresp1}); end
        n_cmp++; if (hrdata1 !== 32'h0) begin n_err++; $display("FAIL reset_ws1_hrdata: got %08h want 00000000", hrdata1); end
        n_cmp++; if ({hreadyout0, hresp0} !== 3'b100) begin n_err++; $display("FAIL reset_ws0_ready_resp: got %b want 100", {hreadyout0, hresp0}); end
        n_cmp++; if (hrdata0 !== 32'h0) begin n_err++; $display("FAIL reset_ws0_hrdata: got %08h want 00000000", hrdata0); end
        hrst = 1'b0;
        step();
        $display("reset done");
    endtask

    task automatic test_word_rw();
        logic [2:0] c1, c2;
        logic [31:0] rd;
        xfer1(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, c1, c2, rd);
        n_cmp++; if (c1 !== 3'b000) begin n_err++; $display("FAIL wr10_wait: got %b want 000", c1); end
        n_cmp++; if (c2 !== 3'b100) begin n_err++; $display("FAIL wr10_data: got %b want 100", c2); end
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL wr10_hrdata_zero: got %08h want 00000000", rd); end
        xfer1(32'h10, 1'b0, 3'd2, 32'h0, c1, c2, rd);
        n_cmp++; if (c1 !== 3'b000) begin n_err++; $display("FAIL rd10_wait: got %b want 000", c1); end
        n_cmp++; if (c2 !== 3'b100) begin n_err++; $display("FAIL rd10_data: got %b want 100", c2); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd10_value: got %08h want deadbeef", rd); end
    endtask

    task automatic test_byte_half_write();
        logic [2:0] c1, c2;
        logic [31:0] rd;
        xfer1(32'h10, 1'b1, 3'd2, 32'h11223344, c1, c2, rd);
        xfer1(32'h13, 1'b1, 3'd0, 32'hAA998877, c1, c2, rd);
        n_cmp++; if (c2 !== 3'b100) begin n_err++; $display("FAIL byte13_resp: got %b want 100", c2); end
        xfer1(32'h10, 1'b0, 3'd2, 32'h0, c1, c2, rd);
        n_cmp++; if (rd !== 32'hAA223344) begin n_err++; $display("FAIL byte13_readback: got %08h want aa223344", rd); end
        xfer1(32'h10, 1'b1, 3'd1, 32'h99885678, c1, c2, rd);
        xfer1(32'h10, 1'b0, 3'd2, 32'h0, c1, c2, rd);
        n_cmp++; if (rd !== 32'hAA225678) begin n_err++; $display("FAIL half10_readback: got %08h want aa225678", rd); end
        xfer1(32'h12, 1'b1, 3'd1, 32'hBEEF1111, c1, c2, rd);
        xfer1(32'h10, 1'b0, 3'd0, 32'h0, c1, c2, rd);
        n_cmp++; if (rd !== 32'hBEEF5678) begin n_err++; $display("FAIL half12_readback: got %08h want beef5678", rd); end
    endtask

    task automatic test_error();
        logic [2:0] c1, c2;
        logic [31:0] rd;
        xfer1(32'h0, 1'b1, 3'd2, 32'h0BADF00D, c1, c2, rd);
        xfer1(32'h1002, 1'b0, 3'd2, 32'h0, c1, c2, rd);
        n_cmp++; if (c1 !== 3'b001) begin n_err++; $display("FAIL rd1002_err1: got %b want 001", c1); end
        n_cmp++; if (c2 !== 3'b101) begin n_err++; $display("FAIL rd1002_err2: got %b want 101", c2); end
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rd1002_hrdata: got %08h want 00000000", rd); end
        xfer1(32'h12, 1'b1, 3'd2, 32'hFFFFFFFF, c1, c2, rd);
        n_cmp++; if ({c1, c2} !== 6'b001101) begin n_err++; $display("FAIL wr12_misaligned: got %b want 001101", {c1, c2}); end
        xfer1(32'h10, 1'b0, 3'd2, 32'h0, c1, c2, rd);
        n_cmp++; if (rd !== 32'hBEEF5678) begin n_err++; $display("FAIL misaligned_nowrite: got %08h want beef5678", rd); end
        xfer1(32'h1000, 1'b1, 3'd2, 32'hCAFEF00D, c1, c2, rd);
        n_cmp++; if ({c1, c2} !== 6'b001101) begin n_err++; $display("FAIL wr1000_range: got %b want 001101", {c1, c2}); end
        xfer1(32'h0, 1'b0, 3'd2, 32'h0, c1, c2, rd);
        n_cmp++; if (rd !== 32'h0BADF00D) begin n_err++; $display("FAIL range_nowrite: got %08h want 0badf00d", rd); end
        xfer1(32'h11, 1'b1, 3'd1, 32'h12345678, c1, c2, rd);
        n_cmp++; if ({c1, c2} !== 6'b001101) begin n_err++; $display("FAIL half11_misaligned: got %b want 001101", {c1, c2}); end
        xfer1(32'h20, 1'b0, 3'd3, 32'h0, c1, c2, rd);
        n_cmp++; if ({c1, c2} !== 6'b001101) begin n_err++; $display("FAIL size3_illegal: got %b want 001101", {c1, c2}); end
        xfer1(32'h10, 1'b0, 3'd2, 32'h0, c1, c2, rd);
        n_cmp++; if (rd !== 32'hBEEF5678) begin n_err++; $display("FAIL err_mem_intact: got %08h want beef5678", rd); end
    endtask

    task automatic test_ignored_phases();
        logic [2:0] c1, c2;
        logic [31:0] rd;
        hready_en = 1'b0;
        hsel1 = 1'b1; haddr = 32'h10; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = 3'd2;
        step();
        n_cmp++; if ({hreadyout1, hresp1} !== 3'b100) begin n_err++; $display("FAIL hready_low_ignored: got %b want 100", {hreadyout1, hresp1}); end
        hready_en = 1'b1;
        htrans = HTRANS_BUSY; hwdata = 32'h55555555;
        step();
        n_cmp++; if ({hreadyout1, hresp1} !== 3'b100) begin n_err++; $display("FAIL busy_ignored: got %b want 100", {hreadyout1, hresp1}); end
        hsel1 = 1'b0; htrans = HTRANS_NONSEQ;
        step();
        n_cmp++; if ({hreadyout1, hresp1} !== 3'b100) begin n_err++; $display("FAIL unselected_ignored: got %b want 100", {hreadyout1, hresp1}); end
        idle_bus();
        step();
        $display("ignored phases: hready low, BUSY, hsel low");
        xfer1(32'h10, 1'b0, 3'd2, 32'h0, c1, c2, rd);
        n_cmp++; if (rd !== 32'hBEEF5678) begin n_err++; $display("FAIL ignored_nowrite: got %08h want beef5678", rd); end
    endtask

    task automatic test_back_to_back();
        hsel0 = 1'b1; haddr = 32'h20; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = 3'd2;
        step();
        n_cmp++; if ({hreadyout0, hresp0} !== 3'b100) begin n_err++; $display("FAIL b2b_wr_data: got %b want 100", {hreadyout0, hresp0}); end
        hwdata = 32'h13579BDF;
        haddr = 32'h20; hwrite = 1'b0;
        step();
        n_cmp++; if ({hreadyout0, hresp0} !== 3'b100) begin n_err++; $display("FAIL b2b_rd_data: got %b want 100", {hreadyout0, hresp0}); end
        n_cmp++; if (hrdata0 !== 32'h13579BDF) begin n_err++; $display("FAIL b2b_rd_value: got %08h want 13579bdf", hrdata0); end
        idle_bus();
        step();
        n_cmp++; if (hrdata0 !== 32'h0) begin n_err++; $display("FAIL b2b_idle_hrdata: got %08h want 00000000", hrdata0); end
        $display("b2b WR/RD addr=00000020 data=13579bdf");
    endtask

    task automatic test_reset_mid_transfer();
        logic [2:0] c1, c2;
        logic [31:0] rd;
        xfer1(32'h30, 1'b1, 3'd2, 32'h01020304, c1, c2, rd);
        hsel1 = 1'b1; haddr = 32'h30; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = 3'd2;
        step();
        n_cmp++; if (hreadyout1 !== 1'b0) begin n_err++; $display("FAIL rstmid_wait: got %b want 0", hreadyout1); end
        idle_bus();
        hwdata = 32'hFFFFFFFF;
        hrst = 1'b1;
        step();
        n_cmp++; if ({hreadyout1, hresp1} !== 3'b100) begin n_err++; $display("FAIL rstmid_after: got %b want 100", {hreadyout1, hresp1}); end
        hrst = 1'b0;
        step();
        $display("reset during WAIT of write to 00000030");
        xfer1(32'h30, 1'b0, 3'd2, 32'h0, c1, c2, rd);
        n_cmp++; if (rd !== 32'h01020304) begin n_err++; $display("FAIL rstmid_nowrite: got %08h want 01020304", rd); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half_write();
        test_error();
        test_ignored_phases();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- AHB-Lite memory responder: the slave end of the AHB bus the team's UVC drives and the protocol checker monitors.
- Accepts NONSEQ/SEQ transfers, inserts a fixed number of wait states, and performs byte/halfword/word reads and writes into an internal word array.
- Returns a two-cycle ERROR response for illegal transfers.
- Serves as the DUT behind the AHB UVC environment.

Parameters:
- MEM_DEPTH, 1024: number of 32-bit words; legal byte window is ADDR_BASE to ADDR_BASE+4*MEM_DEPTH-1.
- ADDR_BASE, 32'h0000_0000: base byte address of the window.
- WAIT_STATES, 1: wait cycles per OKAY transfer; legal range 0..4, so hreadyout rises within 1..5 cycles of an accepted transfer.

Ports:
- hclk  in  1  clock; all logic on posedge.
- hrst  in  1  reset, synchronous, active-high.
- hsel  in  1  slave select.
- haddr  in  32  byte address.
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  in  1  1 = write.
- hsize  in  3  0=byte, 1=half, 2=word; larger values are illegal.
- hburst  in  3  accepted, not used for decoding.
- hprot  in  4  accepted, ignored.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus ready (slave hreadyout after the mux).
- hrdata  out  32  read data.
- hreadyout  out  1  transfer-done indication.
- hresp  out  2  00=OKAY, 01=ERROR.

Behaviour:
- Reset (hrst high at posedge): state IDLE, hreadyout=1, hresp=00, hrdata=0, wait counter=0. Memory contents are not reset. Reset mid-transfer abandons the transfer; a pending write is not committed.
- Accept condition: hsel & hready & htrans[1] at posedge. On acceptance, latch haddr, hwrite and hsize.
- Non-accepted address phases: IDLE, BUSY, or hsel=0 produce no data phase; outputs stay hreadyout=1, hresp=00.
- Legal transfer, all of the following true:
  - address inside the window;
  - hsize <= 2;
  - address aligned to the size (half: haddr[0]=0; word: haddr[1:0]=0).
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE to WAIT: legal accept with WAIT_STATES>0; load counter = WAIT_STATES-1.
  - IDLE to DATA: legal accept with WAIT_STATES=0.
  - IDLE to ERR1: illegal accept.
  - WAIT: hreadyout=0, hresp=00. Decrement counter; go to DATA when counter==0.
  - DATA: hreadyout=1, hresp=00, one cycle.
    - Read: hrdata = mem[latched word index], combinational from the array.
    - Write: hwdata lanes are written at the posedge ending DATA, using byte enables from hsize and haddr[1:0] (little-endian).
    - At that same posedge the next address phase is evaluated; it may go straight to WAIT, DATA or ERR1, giving back-to-back transfers with no bubble.
  - ERR1: hreadyout=0, hresp=01, then to ERR2.
  - ERR2: hreadyout=1, hresp=01. No memory write occurs. The next address phase is evaluated at the end of ERR2; the master may cancel by driving IDLE.
- hrdata is 0 outside a read DATA cycle. Byte and half reads return the full word; the master selects the lane.
- Read-after-write to the same address in consecutive transfers returns the new data. The write commits at the same edge the read enters its data phase, so no forwarding is needed.
- Address phases seen while hready=0 are ignored.
- hburst is ignored: each beat is decoded independently, and address wrap is the master's responsibility.

Decomposition:
- Package ahb_pkg holds:
  - htrans_e (IDLE, BUSY, NONSEQ, SEQ);
  - hsize_e;
  - HRESP_OKAY / HRESP_ERROR constants;
  - slave state enum;
  - function byte_en(hsize, addr[1:0]) returning a 4-bit mask.
- One sub-module, ahb_mem_array: MEM_DEPTH x 32 array with 4-bit byte-enable write and asynchronous read.

Test Plan:
- WAIT_STATES=1: word write 0xDEADBEEF to 0x10, then word read from 0x10. Each transfer shows hreadyout low for 1 cycle; the read DATA cycle gives hrdata=0xDEADBEEF, hresp=00.
- Byte write 0xAA to 0x13 over a word holding 0x11223344, then word read from 0x10 -> 0xAA223344.
- Word read at 0x1002 (misaligned) -> ERR1 (hreadyout=0, hresp=01), then ERR2 (hreadyout=1, hresp=01); memory unchanged.
- Write to 0x1000 with MEM_DEPTH=1024 (out of range) -> two-cycle ERROR; a following read of 0x0 returns its prior value.
- WAIT_STATES=0: back-to-back NONSEQ write to 0x20 then read from 0x20 -> hreadyout stays 1 throughout and the read returns the written data.
- hrst asserted during WAIT of a write to 0x30 -> next cycle hreadyout=1, hresp=00; a later read of 0x30 returns the old data.
